// File: rtl/dpll_lock_ctrl.sv
`default_nettype none
// ============================================================================
// Module   : dpll_lock_ctrl
// Purpose  : DPLL lock detector counting loop-filter corrections per window,
//            stepping IDLE -> ACQ -> SETTLE -> LOCK and choosing filter peak.
// Option   : DPLL_LOSS_STICKY_EN adds loss_clr input and loss_sticky output.
// Revision : 1.0 - initial release
// ============================================================================
module dpll_lock_ctrl #(
  parameter int unsigned WIN_LEN    = 64,
  parameter int unsigned LOCK_THR   = 2,
  parameter int unsigned LOCK_WINS  = 4,
  parameter int unsigned UNLOCK_THR = 8,
  parameter logic [3:0]  PEAK_ACQ   = 4'd9,
  parameter logic [3:0]  PEAK_TRK   = 4'd15
) (
  input  logic       clk,
  input  logic       rst_n,
  input  logic       en,
  input  logic       add,
  input  logic       sub,
`ifdef DPLL_LOSS_STICKY_EN
  input  logic       loss_clr,
  output logic       loss_sticky,
`endif
  output logic [3:0] peak,
  output logic       filt_clr,
  output logic [1:0] state,
  output logic       locked,
  output logic       loss
);

  typedef enum logic [1:0] {
    ST_IDLE   = 2'd0,
    ST_ACQ    = 2'd1,
    ST_SETTLE = 2'd2,
    ST_LOCK   = 2'd3
  } state_t;

  localparam logic [7:0] WIN_LAST     = 8'(WIN_LEN - 1);
  localparam logic [8:0] LOCK_THR_C   = 9'(LOCK_THR);
  localparam logic [8:0] UNLOCK_THR_C = 9'(UNLOCK_THR);
  localparam logic [3:0] LOCK_WINS_C  = 4'(LOCK_WINS);

  state_t     state_q, state_d;
  logic [7:0] win_cnt_q, win_cnt_d;
  logic [7:0] corr_cnt_q, corr_cnt_d;
  logic [3:0] quiet_cnt_q, quiet_cnt_d;
  logic [3:0] peak_q, peak_d;
  logic       filt_clr_q, filt_clr_d;
  logic       loss_q, loss_d;

  logic       corr;
  logic [8:0] corr_sum;
  logic [7:0] corr_tot;
  logic       win_end;
  logic       quiet;
  logic       noisy_lock;
  logic [3:0] quiet_inc;
  logic       entry;

  always_comb begin
    corr       = add | sub;
    corr_sum   = {1'b0, corr_cnt_q} + {8'd0, corr};
    // Total includes the current cycle so the window's last cycle is counted.
    corr_tot   = corr_sum[8] ? 8'hFF : corr_sum[7:0];
    win_end    = (win_cnt_q == WIN_LAST);
    quiet      = ({1'b0, corr_tot} <= LOCK_THR_C);
    noisy_lock = ({1'b0, corr_tot} > UNLOCK_THR_C);
    quiet_inc  = quiet_cnt_q + 4'd1;

    state_d     = state_q;
    quiet_cnt_d = quiet_cnt_q;
    loss_d      = 1'b0;

    case (state_q)
      ST_IDLE: begin
        state_d     = ST_ACQ;
        quiet_cnt_d = 4'd0;
      end
      ST_ACQ: begin
        if (win_end) begin
          if (!quiet) begin
            quiet_cnt_d = 4'd0;
          end else if (quiet_inc >= LOCK_WINS_C) begin
            state_d     = ST_SETTLE;
            quiet_cnt_d = 4'd0;
          end else begin
            quiet_cnt_d = quiet_inc;
          end
        end
      end
      ST_SETTLE: begin
        if (win_end) begin
          state_d = quiet ? ST_LOCK : ST_ACQ;
        end
      end
      ST_LOCK: begin
        if (win_end && noisy_lock) begin
          state_d = ST_ACQ;
          loss_d  = 1'b1;
        end
      end
      default: state_d = ST_IDLE;
    endcase

    if (!en) begin
      state_d     = ST_IDLE;
      quiet_cnt_d = 4'd0;
      loss_d      = 1'b0;
    end

    entry = (state_d != state_q);

    if ((state_d == ST_IDLE) || entry || win_end) begin
      win_cnt_d  = 8'd0;
      corr_cnt_d = 8'd0;
    end else begin
      win_cnt_d  = win_cnt_q + 8'd1;
      corr_cnt_d = corr_tot;
    end

    filt_clr_d = entry && ((state_d == ST_ACQ) || (state_d == ST_SETTLE));
    peak_d     = ((state_d == ST_SETTLE) || (state_d == ST_LOCK)) ? PEAK_TRK : PEAK_ACQ;
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q     <= ST_IDLE;
      win_cnt_q   <= 8'd0;
      corr_cnt_q  <= 8'd0;
      quiet_cnt_q <= 4'd0;
      peak_q      <= PEAK_ACQ;
      filt_clr_q  <= 1'b0;
      loss_q      <= 1'b0;
    end else begin
      state_q     <= state_d;
      win_cnt_q   <= win_cnt_d;
      corr_cnt_q  <= corr_cnt_d;
      quiet_cnt_q <= quiet_cnt_d;
      peak_q      <= peak_d;
      filt_clr_q  <= filt_clr_d;
      loss_q      <= loss_d;
    end
  end

  assign state    = state_q;
  assign peak     = peak_q;
  assign filt_clr = filt_clr_q;
  assign loss     = loss_q;
  assign locked   = (state_q == ST_LOCK);

`ifdef DPLL_LOSS_STICKY_EN
  logic loss_sticky_q, loss_sticky_d;

  // A loss pulse seen in the same cycle as loss_clr keeps the flag set.
  always_comb begin
    loss_sticky_d = loss_q | (loss_sticky_q & ~loss_clr);
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      loss_sticky_q <= 1'b0;
    end else begin
      loss_sticky_q <= loss_sticky_d;
    end
  end

  assign loss_sticky = loss_sticky_q;
`endif

endmodule
`default_nettype wire
